node_id_scanner: RTL and testbench

Parametrised genome scanner for the NEAT datapath. Accepts a stream of node genes over a valid/ready handshake and tracks, per layer code, the maximum node ID and the gene count. At end of genome it reports the next free node ID for the add-node mutation stage. Sits between the gene memory reader and the mutation/allocation logic, and generalises the single-layer hidden-node maximum tracker to all layers with explicit scan framing.

---
 rtl/node_id_scanner_pkg.sv | 25 ++
 rtl/node_id_scanner_lane.sv | 43 ++++
 rtl/node_id_scanner.sv | 126 ++++++++++++
 tb/tb_node_id_scanner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/node_id_scanner_pkg.sv
// node_id_scanner_pkg: gene field offsets, layer codes and scanner FSM states.
// Rev 1.0
`default_nettype none

package node_id_scanner_pkg;

    localparam int c_GENE_SZ   = 64;
    localparam int c_ATTR_SZ   = 8;
    localparam int c_NODE_LSB  = 5 * c_ATTR_SZ;
    localparam int c_LAYER_LSB = 7 * c_ATTR_SZ - 3;

    localparam logic [1:0] LAYER_HIDDEN = 2'b00;
    localparam logic [1:0] LAYER_INPUT  = 2'b01;
    localparam logic [1:0] LAYER_OUTPUT = 2'b10;
    localparam logic [1:0] LAYER_BIAS   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/node_id_scanner_lane.sv
// node_id_lane: per-layer max node ID register and saturating gene counter.
// Rev 1.0
`default_nettype none

module node_id_lane #(
    parameter int ATTR_SZ = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               upd,
    input  logic [ATTR_SZ-1:0] id,
    output logic [ATTR_SZ-1:0] max_o,
    output logic [CNT_W-1:0]   cnt_o
);

    logic [ATTR_SZ-1:0] max_q;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            max_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            max_q <= '0;
            cnt_q <= '0;
        end else if (upd) begin
            if (id > max_q) begin
                max_q <= id;
            end
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign max_o = max_q;
    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/node_id_scanner.sv
// node_id_scanner: streams node genes, tracks per-layer max ID / count, reports next free ID.
// Rev 1.0
`default_nettype none

module node_id_scanner
    import node_id_scanner_pkg::*;
#(
    parameter int GENE_SZ    = c_GENE_SZ,
    parameter int ATTR_SZ    = c_ATTR_SZ,
    parameter int NODE_LSB   = 5 * ATTR_SZ,
    parameter int LAYER_LSB  = 7 * ATTR_SZ - 3,
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          gene_valid,
    output logic                          gene_ready,
    input  logic                          gene_last,
    input  logic [GENE_SZ-1:0]            gene_in,
    output logic [NUM_LAYERS*ATTR_SZ-1:0] layer_max,
    output logic [NUM_LAYERS*CNT_W-1:0]   layer_cnt,
    output logic [ATTR_SZ-1:0]            next_node_id,
    output logic                          id_overflow,
    output logic                          busy,
    output logic                          done
);

    scan_state_e        state_q, state_d;
    logic [ATTR_SZ-1:0] next_id_q, next_id_d;
    logic               ovf_q, ovf_d;
    logic               done_q;

    logic                  w_clr;
    logic                  w_accept;
    logic [1:0]            w_layer;
    logic [ATTR_SZ-1:0]    w_id;
    logic [NUM_LAYERS-1:0] w_upd;
    logic [ATTR_SZ-1:0]    w_max [NUM_LAYERS];
    logic [ATTR_SZ-1:0]    w_gmax;
    logic                  w_unused;

    // Only the layer and node ID fields matter here; the rest of the gene is ignored.
    assign w_unused = ^gene_in;
    assign w_layer  = gene_in[LAYER_LSB +: 2];
    assign w_id     = gene_in[NODE_LSB +: ATTR_SZ];
    assign w_clr    = (state_q == S_IDLE) && start;
    assign w_accept = (state_q == S_SCAN) && gene_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SCAN;
            S_SCAN:  if (gene_valid && gene_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    generate
        for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_lane
            // Codes without a lane never match, so they are accepted but not counted.
            assign w_upd[k] = w_accept && (32'(w_layer) == k);

            node_id_lane #(
                .ATTR_SZ (ATTR_SZ),
                .CNT_W   (CNT_W)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .clr   (w_clr),
                .upd   (w_upd[k]),
                .id    (w_id),
                .max_o (w_max[k]),
                .cnt_o (layer_cnt[k*CNT_W +: CNT_W])
            );

            assign layer_max[k*ATTR_SZ +: ATTR_SZ] = w_max[k];
        end
    endgenerate

    always_comb begin
        w_gmax = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (w_max[k] > w_gmax) begin
                w_gmax = w_max[k];
            end
        end
    end

    always_comb begin
        next_id_d = next_id_q;
        ovf_d     = ovf_q;
        if (w_clr) begin
            next_id_d = '0;
            ovf_d     = 1'b0;
        end else if (state_q == S_DONE) begin
            ovf_d     = (w_gmax == '1);
            next_id_d = (w_gmax == '1) ? '1 : w_gmax + ATTR_SZ'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            next_id_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_id_q <= next_id_d;
            ovf_q     <= ovf_d;
            done_q    <= (state_q == S_DONE);
        end
    end

    assign gene_ready   = (state_q == S_SCAN);
    assign busy         = (state_q == S_SCAN);
    assign done         = done_q;
    assign next_node_id = next_id_q;
    assign id_overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_node_id_scanner.sv
// tb_node_id_scanner: directed and randomized genomes checked against a per-layer reference model.
// Rev 1.0
`default_nettype none

module tb_node_id_scanner;

    localparam int c_NODE_LSB  = 40;
    localparam int c_LAYER_LSB = 53;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        gene_valid = 1'b0;
    logic        gene_last = 1'b0;
    logic [63:0] gene_in = '0;
    logic        gene_ready;
    logic [31:0] layer_max;
    logic [31:0] layer_cnt;
    logic [7:0]  next_node_id;
    logic        id_overflow;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] q_lay[$];
    logic [7:0] q_id[$];

    always #5 clk = ~clk;

    node_id_scanner u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .gene_valid   (gene_valid),
        .gene_ready   (gene_ready),
        .gene_last    (gene_last),
        .gene_in      (gene_in),
        .layer_max    (layer_max),
        .layer_cnt    (layer_cnt),
        .next_node_id (next_node_id),
        .id_overflow  (id_overflow),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] make_gene(input logic [1:0] lay, input logic [7:0] id);
        logic [63:0] g;
        g = {$urandom, $urandom};
        g[c_LAYER_LSB +: 2] = lay;
        g[c_NODE_LSB +: 8]  = id;
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: statistics computed directly from the recorded genome.
    task automatic check_results(input string tag);
        int          ecnt[4];
        logic [7:0]  emax[4];
        logic [7:0]  gmax;
        for (int k = 0; k < 4; k++) begin
            ecnt[k] = 0;
            emax[k] = 8'h00;
        end
        for (int i = 0; i < q_lay.size(); i++) begin
            if (q_id[i] > emax[q_lay[i]]) emax[q_lay[i]] = q_id[i];
            ecnt[q_lay[i]] = (ecnt[q_lay[i]] < 255) ? ecnt[q_lay[i]] + 1 : 255;
        end
        gmax = 8'h00;
        for (int k = 0; k < 4; k++) if (emax[k] > gmax) gmax = emax[k];
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s:max%0d", tag, k), 64'(layer_max[k*8 +: 8]), 64'(emax[k]));
            check($sformatf("%s:cnt%0d", tag, k), 64'(layer_cnt[k*8 +: 8]), 64'(ecnt[k]));
        end
        check({tag, ":next"}, 64'(next_node_id), (gmax == 8'hFF) ? 64'hFF : 64'(gmax) + 64'd1);
        check({tag, ":ovf"}, 64'(id_overflow), (gmax == 8'hFF) ? 64'd1 : 64'd0);
    endtask

    task automatic run_genome(input string tag, input bit gaps, input bit start_mid, input bit start_done);
        int n;
        n = q_lay.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ":ready_scan"}, 64'(gene_ready), 64'd1);
        check({tag, ":busy_scan"}, 64'(busy), 64'd1);
        check({tag, ":clr_cnt"}, 64'(layer_cnt), 64'd0);
        check({tag, ":clr_max"}, 64'(layer_max), 64'd0);
        check({tag, ":clr_next"}, 64'(next_node_id), 64'd0);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    gene_valid = 1'b0;
                    gene_in    = make_gene(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
                    gene_last  = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            gene_valid = 1'b1;
            gene_in    = make_gene(q_lay[i], q_id[i]);
            gene_last  = (i == n - 1);
            start      = start_mid && (i == n / 2);
            tick();
            start = 1'b0;
        end
        gene_valid = 1'b0;
        gene_last  = 1'b0;
        check({tag, ":ready_donest"}, 64'(gene_ready), 64'd0);
        check({tag, ":done_early"}, 64'(done), 64'd0);
        start = start_done;
        tick();
        start = 1'b0;
        check({tag, ":done"}, 64'(done), 64'd1);
        check({tag, ":busy_done"}, 64'(busy), 64'd0);
        check({tag, ":ready_idle"}, 64'(gene_ready), 64'd0);
        check_results({tag, ":res"});
        tick();
        check({tag, ":done_once"}, 64'(done), 64'd0);
        check({tag, ":ready_idle2"}, 64'(gene_ready), 64'd0);
        check_results({tag, ":hold"});
    endtask

    task automatic load_mixed();
        q_lay = {2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
        q_id  = {8'h01, 8'h02, 8'h03, 8'h07, 8'h05};
    endtask

    initial begin
        // Power-on reset
        rst = 1'b0;
        tick();
        tick();
        check("rst:ready", 64'(gene_ready), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:done", 64'(done), 64'd0);
        check("rst:max", 64'(layer_max), 64'd0);
        check("rst:cnt", 64'(layer_cnt), 64'd0);
        check("rst:next", 64'(next_node_id), 64'd0);
        check("rst:ovf", 64'(id_overflow), 64'd0);
        rst = 1'b1;
        tick();

        // Reset in the middle of a scan
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gene_valid = 1'b1;
            gene_in    = make_gene(2'(i), 8'h20 + 8'(i));
            tick();
        end
        gene_valid = 1'b0;
        check("midrst:cnt_before", 64'(layer_cnt), 64'h0000_0000_0001_0101);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst:ready", 64'(gene_ready), 64'd0);
        check("midrst:busy", 64'(busy), 64'd0);
        check("midrst:max", 64'(layer_max), 64'd0);
        check("midrst:cnt", 64'(layer_cnt), 64'd0);
        tick();
        check("midrst:ready_next", 64'(gene_ready), 64'd0);

        load_mixed();
        run_genome("mixed", 1'b0, 1'b0, 1'b0);
        check("mixed:max_lit", 64'(layer_max), 64'h0000_0000_0003_0207);
        check("mixed:cnt_lit", 64'(layer_cnt), 64'h0000_0000_0001_0202);
        check("mixed:next_lit", 64'(next_node_id), 64'h08);

        load_mixed();
        run_genome("gaps", 1'b1, 1'b0, 1'b0);

        q_lay = {2'd3};
        q_id  = {8'hFF};
        run_genome("ovf", 1'b0, 1'b0, 1'b0);
        check("ovf:next_lit", 64'(next_node_id), 64'hFF);
        check("ovf:flag_lit", 64'(id_overflow), 64'd1);

        q_lay.delete();
        q_id.delete();
        for (int i = 0; i < 300; i++) begin
            q_lay.push_back(2'd0);
            q_id.push_back(8'h10);
        end
        run_genome("sat", 1'b0, 1'b0, 1'b0);
        check("sat:cnt_lit", 64'(layer_cnt[7:0]), 64'hFF);
        check("sat:next_lit", 64'(next_node_id), 64'h11);

        load_mixed();
        run_genome("startign", 1'b0, 1'b1, 1'b1);
        q_lay = {2'd0};
        q_id  = {8'h00};
        run_genome("after", 1'b0, 1'b0, 1'b0);
        check("after:next_lit", 64'(next_node_id), 64'h01);

        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 20);
            q_lay.delete();
            q_id.delete();
            for (int i = 0; i < len; i++) begin
                q_lay.push_back(2'($urandom_range(0, 3)));
                q_id.push_back(($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
            end
            run_genome($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
